// File: rtl/rsa_two_power_pkg.sv
// Shared RSA types: key width, the raw job record and the Montgomery-ready record
// that the exponentiation stage consumes.
package RSA_pkg;

    localparam int MOD_WIDTH = 256;

    typedef logic [MOD_WIDTH-1:0] KeyType;

    typedef struct packed {
        KeyType base;
        KeyType msg;
        KeyType key;
        KeyType modulus;
    } RSAMontModIn;

    typedef struct packed {
        KeyType msg;
        KeyType key;
        KeyType modulus;
    } RSAModIn;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } two_power_state_e;

endpackage

// File: rtl/rsa_two_power_mod_double.sv
// Combinational modular doubling: r2_o = (2 * r_i) mod modulus_i, valid while r_i < modulus_i.
// modulus_i == 0 with r_i == 0 yields 0.
module rsa_mod_double #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] modulus_i,
    output logic [WIDTH-1:0] r2_o
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] m;

    assign t = {r_i, 1'b0};
    assign m = {1'b0, modulus_i};

    // One extra bit holds 2r exactly. The reduced value always fits back into WIDTH bits.
    assign r2_o = WIDTH'((t >= m) ? (t - m) : t);

endmodule

// File: rtl/rsa_two_power.sv
// Computes base = 2^N_DOUBLE mod modulus by repeated modular doubling, then emits {base, msg, key, modulus}.
// Define RSA_TWO_POWER_RADIX4_EN to do two doublings per cycle. This halves the latency.
module rsa_two_power
    import RSA_pkg::*;
#(
    parameter int N_DOUBLE = 2 * MOD_WIDTH,
    parameter int WIDTH    = MOD_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  RSAModIn     i_in,
    output logic        o_valid,
    input  logic        o_ready,
    output RSAMontModIn o_out
);

    localparam int CNT_W = $clog2(N_DOUBLE + 1);

    if (WIDTH != MOD_WIDTH) begin : g_width_chk
        $error("rsa_two_power: WIDTH must equal MOD_WIDTH");
    end

    two_power_state_e   state_q;
    logic [WIDTH-1:0]   msg_q;
    logic [WIDTH-1:0]   key_q;
    logic [WIDTH-1:0]   mod_q;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               i_ready_q;
    logic               o_valid_q;
    RSAMontModIn        o_out_q;

`ifdef RSA_TWO_POWER_RADIX4_EN
    localparam int STEP = 2;
    logic [WIDTH-1:0] r_mid;

    if (N_DOUBLE % 2 != 0) begin : g_even_chk
        $error("rsa_two_power: N_DOUBLE must be even when RSA_TWO_POWER_RADIX4_EN is defined");
    end

    rsa_mod_double #(.WIDTH(WIDTH)) u_dbl0 (
        .r_i       (r_q),
        .modulus_i (mod_q),
        .r2_o      (r_mid)
    );

    rsa_mod_double #(.WIDTH(WIDTH)) u_dbl1 (
        .r_i       (r_mid),
        .modulus_i (mod_q),
        .r2_o      (r_d)
    );
`else
    localparam int STEP = 1;

    rsa_mod_double #(.WIDTH(WIDTH)) u_dbl0 (
        .r_i       (r_q),
        .modulus_i (mod_q),
        .r2_o      (r_d)
    );
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DOUBLE - STEP);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(STEP);

    // NOTE: all state uses non-blocking assignments in one clocked block. The order
    // of the statements below therefore never changes which value a register samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            msg_q     <= '0;
            key_q     <= '0;
            mod_q     <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            i_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
            o_out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid && i_ready_q) begin
                        msg_q     <= i_in.msg;
                        key_q     <= i_in.key;
                        mod_q     <= i_in.modulus;
                        r_q       <= {{(WIDTH-1){1'b0}}, (i_in.modulus > KeyType'(1))};
                        cnt_q     <= '0;
                        i_ready_q <= 1'b0;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    r_q   <= r_d;
                    cnt_q <= cnt_q + CNT_STEP;
                    if (cnt_q == CNT_LAST) begin
                        // Load the output from the final step now, so it is valid as DONE is entered.
                        o_out_q   <= '{base: r_d, msg: msg_q, key: key_q, modulus: mod_q};
                        o_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid_q <= 1'b0;
                        i_ready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    o_valid_q <= 1'b0;
                    i_ready_q <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign i_ready = i_ready_q;
    assign o_valid = o_valid_q;
    assign o_out   = o_out_q;

endmodule

// File: doc/rsa_two_power.md
Name: rsa_two_power

Overview:
- Pre-processing stage sitting directly upstream of the RSA Montgomery exponentiation stage.
- Accepts a raw job (msg, key, modulus) and computes the Montgomery conversion constant base = 2^N_DOUBLE mod modulus by iterative modular doubling.
- Emits the full packed RSAMontModIn record {base, msg, key, modulus} that the exponentiation stage consumes.
- Valid/ready on both sides; one job in flight at a time.

Parameters:
- N_DOUBLE, default 2*MOD_WIDTH (512): number of modular doublings, so base = 2^N_DOUBLE mod modulus.
- WIDTH, default MOD_WIDTH (256): operand width; must equal the KeyType width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- i_valid  input  1  job valid
- i_ready  output  1  block can accept a job
- i_in  input  RSAModIn (3*WIDTH)  {msg, key, modulus}
- o_valid  output  1  result valid
- o_ready  input  1  downstream accepts result
- o_out  output  RSAMontModIn (4*WIDTH)  {base, msg, key, modulus}

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE, i_ready = 1, o_valid = 0.
  - o_out = 0; all internal registers = 0.
- FSM states and transitions:
  - IDLE: i_ready = 1. On i_valid && i_ready:
    - latch msg, key, modulus;
    - r <= (modulus > 1) ? 1 : 0;
    - cnt <= 0; go to CALC.
  - CALC: i_ready = 0, o_valid = 0. Each cycle:
    - t = {r, 1'b0}, computed WIDTH+1 bits wide;
    - r <= (t >= {1'b0, modulus}) ? t - modulus : t, truncated to WIDTH;
    - cnt <= cnt + 1;
    - when cnt == N_DOUBLE-1, go to DONE.
  - DONE: o_valid = 1; o_out = {r, msg, key, modulus}. On o_ready, go to IDLE.
- Widths:
  - cnt is $clog2(N_DOUBLE+1) bits.
  - Invariant r < modulus whenever modulus > 1.
  - The comparison and subtraction are WIDTH+1 bits, with no overflow.
- Latency: if the job is accepted at edge k, o_valid is first high in the cycle after edge k+N_DOUBLE (N_DOUBLE+1 edges total).
  - Throughput: one job per N_DOUBLE+2 cycles at best.
- Handshake rules:
  - o_out and o_valid are held stable while o_valid && !o_ready.
  - i_ready is low in CALC and DONE; no input is ever dropped.
  - i_ready is never combinationally dependent on o_ready. The next job is accepted only from IDLE, i.e. the cycle after the output handshake.
- Degenerate moduli:
  - modulus == 1 yields base = 0.
  - modulus == 0 yields base = 0: r stays 0 because 0 >= 0 subtracts 0.
  - Even moduli are not rejected; the result is still the correct 2^N_DOUBLE mod modulus.
- Reset mid-operation: rst asserted in any state returns to IDLE on the next edge, clears o_valid, and discards the in-flight job.
- Simultaneous rst and i_valid: rst wins; the job is not accepted.

Optional Feature:
- Macro: RSA_TWO_POWER_RADIX4_EN.
- Defined:
  - two doubling steps are chained combinationally per cycle;
  - cnt advances by 2; CALC exits when cnt == N_DOUBLE-2;
  - latency is N_DOUBLE/2 + 1 edges;
  - N_DOUBLE must be even (elaboration-time $error otherwise).
- Undefined: one doubling per cycle, as specified above. The result value is identical in both builds.

Decomposition:
- Package RSA_pkg:
  - add typedef RSAModIn {KeyType msg, key, modulus};
  - reuse MOD_WIDTH, KeyType and RSAMontModIn unchanged.
- Sub-module rsa_mod_double:
  - purely combinational: (r, modulus) -> (2r mod modulus);
  - instantiated once, or twice in series under RSA_TWO_POWER_RADIX4_EN.
- FSM, counter and registers stay in rsa_two_power.

Test Plan:
- Basic small moduli, msg = 0x1234, key = 0x10001:
  - modulus = 3 -> base = 1; msg and key are passed through unchanged.
  - modulus = 7 -> base = 4.
  - Check o_valid rises exactly N_DOUBLE+1 edges after accept.
- Large modulus: modulus = 2^256-1 -> base = 1. Also check a random odd 256-bit modulus against a software reference (2^512 mod N).
- Degenerate moduli: modulus = 1 -> base = 0; modulus = 0 -> base = 0; no X on o_out.
- Backpressure: hold o_ready = 0 for 5 cycles after o_valid. o_out must be stable, o_valid must stay 1, and i_ready must stay 0 while i_valid = 1. Release: handshake happens, then the next job is accepted the following cycle.
- Back-to-back: i_valid held high with 3 queued jobs (moduli 3, 7, 2^256-1). Outputs must appear in order with values 1, 4, 1 and no job lost or duplicated.
- Reset mid-calc: assert rst for 1 cycle 100 cycles into CALC. Next cycle: i_ready = 1 and o_valid = 0; no stale output appears. A fresh job with modulus = 7 then yields base = 4.
